regfile_resp: RTL
=================

REGFILE_RESP -- requirements
Module: regfile_resp

Interface
REQ-001 Parameter NUM_REGS, default 16, number of 64-bit registers.
REQ-002 Parameter DATA_W, default 64, register and data width in bits.
REQ-003 Parameter ADDR_W, default 4, address width; SHALL equal clog2(NUM_REGS).
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port read_en  input  2  per-port read request; bit0 = port 0, bit1 = port 1.
REQ-007 Port raddr_0  input  ADDR_W  port 0 read address.
REQ-008 Port raddr_1  input  ADDR_W  port 1 read address.
REQ-009 Port write_en  input  1  write request.
REQ-010 Port waddr  input  ADDR_W  write address.
REQ-011 Port wdata  input  DATA_W  write data.
REQ-012 Port rdata_0  output  DATA_W  port 0 read data, registered.
REQ-013 Port rdata_1  output  DATA_W  port 1 read data, registered.
REQ-014 Port rvalid  output  2  per-port one-cycle pulse marking fresh rdata.
REQ-015 Port rd_uninit  output  2  per-port flag, valid with rvalid: register read before any write since reset.

Function
REQ-016 Write path SHALL be two stages: write_en captures waddr/wdata into a one-entry write buffer (wbuf_valid, wbuf_addr, wbuf_data); the array commits the buffer on the following edge.
REQ-017 wbuf_valid SHALL follow write_en each cycle; consecutive writes SHALL stream with no stall, one per cycle.
REQ-018 Reads SHALL have 1-cycle latency: read_en[p] sampled at edge N gives rdata_p and rvalid[p]=1 after edge N; rvalid[p]=0 otherwise.
REQ-019 rdata_p SHALL hold its last value while rvalid[p]=0.
REQ-020 Read source priority: if wbuf_valid and wbuf_addr==raddr_p, return wbuf_data; else return array[raddr_p].
REQ-021 Read and write_en in the same cycle to the same address SHALL return the pre-write value; the new value SHALL be visible to reads issued from the next cycle on.
REQ-022 Both ports reading the same address in one cycle SHALL return identical data.
REQ-023 Back-to-back writes to the same address SHALL leave the last value; an intervening read SHALL see the value of the most recent prior-cycle write.
REQ-024 A per-register written bitmap SHALL set on write_en capture; rd_uninit[p] = ~written[raddr_p] evaluated at read issue, same forwarding rule as REQ-020/021.
REQ-025 Out-of-range addresses (>= NUM_REGS when not a power of two) SHALL be write-ignored and SHALL read as 0 with rd_uninit=1.

Reset
REQ-026 reset SHALL asynchronously clear all array entries to 0, written bitmap to 0, wbuf_valid to 0, rdata_0/rdata_1 to 0, rvalid to 0, rd_uninit to 0.
REQ-027 Reset asserted mid-operation SHALL discard any buffered uncommitted write and any in-flight read; no rvalid pulse SHALL appear in the cycle reset deasserts.
REQ-028 Requests SHALL be accepted starting from the first rising edge after reset deasserts.

Structure
REQ-029 NUM_REGS, DATA_W, ADDR_W defaults and a wbuf_t struct (valid, addr, data) SHALL live in shared package regfile_pkg.
REQ-030 Per-port read mux plus forwarding logic SHALL be one sub-module, regfile_rd_port, instantiated twice.

Verification
REQ-031 After reset, read reg 5 on both ports -> rvalid=2'b11, rdata=0, rd_uninit=2'b11.
REQ-032 Write 0x0000_0000_0000_0001 to reg 3 at cycle N, read port 0 reg 3 at N+1 -> rdata_0=0x1 at N+2 (forwarded), rd_uninit[0]=0.
REQ-033 Walking ones/zeros: for every register, shift wdata left inserting 1 x64 then 0 x64, reading back via port 0, port 1, then both -> every read matches wdata.
REQ-034 Same-cycle write 0xDEAD_BEEF to reg 7 (old 0x0) with read reg 7 -> rdata=0x0; read next cycle -> 0xDEAD_BEEF.
REQ-035 Writes A=0x11 then B=0x22 to reg 2 on consecutive cycles, read reg 2 every cycle -> 0x0, 0x11, 0x22.
REQ-036 Assert reset one cycle after write_en to reg 9 -> after release, read reg 9 returns 0 with rd_uninit=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and write-buffer record for the two-read/one-write register file.
package regfile_pkg;
  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_DATA_W   = 64;
  localparam int DEF_ADDR_W   = 4;

  // The record is sized by the package defaults.
  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wbuf_t;
endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: address range check, write-buffer forwarding, and the output flops.
module regfile_rd_port #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             read_en,
  input  logic [ADDR_W-1:0]                raddr,
  input  logic                             wbuf_valid,
  input  logic [ADDR_W-1:0]                wbuf_addr,
  input  logic [DATA_W-1:0]                wbuf_data,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
  input  logic [NUM_REGS-1:0]              written,
  output logic [DATA_W-1:0]                rdata,
  output logic                             rvalid,
  output logic                             rd_uninit
);
  logic              in_range;
  logic              hit;
  logic [DATA_W-1:0] rd_mux;
  logic              uninit_mux;

  always_comb begin
    in_range   = 32'(raddr) < NUM_REGS;
    hit        = wbuf_valid && (wbuf_addr == raddr);
    rd_mux     = '0;
    uninit_mux = 1'b1;
    // The written bit is set at capture, so it already covers a buffered write.
    if (in_range) begin
      rd_mux     = hit ? wbuf_data : regs[raddr];
      uninit_mux = ~written[raddr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata     <= '0;
      rvalid    <= 1'b0;
      rd_uninit <= 1'b0;
    end else begin
      rvalid <= read_en;
      if (read_en) begin
        rdata     <= rd_mux;
        rd_uninit <= uninit_mux;
      end
    end
  end
endmodule

// File: rtl/regfile_resp.sv
// Register file with a one-entry write buffer in front of the array and two forwarding read ports.
module regfile_resp
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        read_en,
  input  logic [ADDR_W-1:0] raddr_0,
  input  logic [ADDR_W-1:0] raddr_1,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_0,
  output logic [DATA_W-1:0] rdata_1,
  output logic [1:0]        rvalid,
  output logic [1:0]        rd_uninit
);
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             written;
  wbuf_t                           wbuf;
  logic                            w_ok;

  logic [1:0][ADDR_W-1:0] raddr;
  logic [1:0][DATA_W-1:0] rdata;

  assign w_ok    = write_en && (32'(waddr) < NUM_REGS);
  assign raddr   = {raddr_1, raddr_0};
  assign rdata_0 = rdata[0];
  assign rdata_1 = rdata[1];

  // Capture this cycle, commit next cycle; a reset in between drops the buffered write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs    <= '0;
      written <= '0;
      wbuf    <= '0;
    end else begin
      wbuf.valid <= w_ok;
      if (write_en) begin
        wbuf.addr <= waddr;
        wbuf.data <= wdata;
      end
      if (w_ok) written[waddr] <= 1'b1;
      if (wbuf.valid) regs[wbuf.addr] <= wbuf.data;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd
    regfile_rd_port #(
      .NUM_REGS(NUM_REGS),
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W)
    ) u_rd (
      .clk       (clk),
      .reset     (reset),
      .read_en   (read_en[p]),
      .raddr     (raddr[p]),
      .wbuf_valid(wbuf.valid),
      .wbuf_addr (wbuf.addr),
      .wbuf_data (wbuf.data),
      .regs      (regs),
      .written   (written),
      .rdata     (rdata[p]),
      .rvalid    (rvalid[p]),
      .rd_uninit (rd_uninit[p])
    );
  end
endmodule
